// File: rtl/shiftreg_univ.sv
// Universal shift register with a load handshake: serialises a loaded word LANES bits per beat
// (left/right, shift/rotate) and captures the incoming lanes as a parallel word.
module shiftreg_univ #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_dir,
  input  logic             i_rot,
  input  logic             i_ser_en,
  input  logic [LANES-1:0] i_ser,
  output logic [LANES-1:0] o_ser,
  output logic             o_ser_valid,
  output logic [WIDTH-1:0] o_par,
  output logic             o_par_valid,
  output logic             o_busy
);

  localparam int unsigned N    = WIDTH / LANES;
  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             rot_q, rot_d;

  logic             load_fire;
  logic [LANES-1:0] beat_out;
  logic [LANES-1:0] fill;

  assign o_load_ready = (state_q == StIdle) || (state_q == StDone);
  assign load_fire    = i_load_valid && o_load_ready;

  // Outgoing slice depends only on the latched direction, never on the live i_dir.
  assign beat_out = dir_q ? r_q[LANES-1:0] : r_q[WIDTH-1 -: LANES];
  assign fill     = rot_q ? beat_out : i_ser;

  assign o_ser_valid = (state_q == StShift);
  assign o_ser       = o_ser_valid ? beat_out : '0;
  assign o_par       = r_q;
  assign o_par_valid = (state_q == StDone);
  assign o_busy      = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    rot_d   = rot_q;

    case (state_q)
      StIdle, StDone: begin
        if (load_fire) begin
          r_d     = i_load_data;
          dir_d   = i_dir;
          rot_d   = i_rot;
          cnt_d   = CntW'(N);
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end

      StShift: begin
        if (i_ser_en) begin
          if (dir_q) begin
            r_d = {fill, r_q[WIDTH-1:LANES]};
          end else begin
            r_d = {r_q[WIDTH-LANES-1:0], fill};
          end
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StDone;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
    end
  end

endmodule

// File: tb/tb_shiftreg_univ.sv
// Self-checking bench for shiftreg_univ: three instances (8x1, 8x2, 16x4) checked against a
// beat/word model computed from the shift rules with plain arithmetic.
module tb_shiftreg_univ;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        lv [3];
  logic [63:0] ld [3];
  logic        dr [3];
  logic        rt [3];
  logic        en [3];
  logic [63:0] si [3];

  logic [63:0] so [3];
  logic [63:0] pa [3];
  logic        lr [3];
  logic        sv [3];
  logic        pv [3];
  logic        bz [3];

  logic [0:0]  so0;
  logic [1:0]  so1;
  logic [3:0]  so2;
  logic [7:0]  pa0;
  logic [7:0]  pa1;
  logic [15:0] pa2;

  int tests_run    = 0;
  int tests_failed = 0;

  assign so[0] = 64'(so0);
  assign so[1] = 64'(so1);
  assign so[2] = 64'(so2);
  assign pa[0] = 64'(pa0);
  assign pa[1] = 64'(pa1);
  assign pa[2] = 64'(pa2);

  shiftreg_univ #(.WIDTH(8), .LANES(1)) u_w8l1 (
    .clk(clk), .rst(rst), .i_load_valid(lv[0]), .o_load_ready(lr[0]),
    .i_load_data(ld[0][7:0]), .i_dir(dr[0]), .i_rot(rt[0]), .i_ser_en(en[0]),
    .i_ser(si[0][0:0]), .o_ser(so0), .o_ser_valid(sv[0]), .o_par(pa0),
    .o_par_valid(pv[0]), .o_busy(bz[0])
  );

  shiftreg_univ #(.WIDTH(8), .LANES(2)) u_w8l2 (
    .clk(clk), .rst(rst), .i_load_valid(lv[1]), .o_load_ready(lr[1]),
    .i_load_data(ld[1][7:0]), .i_dir(dr[1]), .i_rot(rt[1]), .i_ser_en(en[1]),
    .i_ser(si[1][1:0]), .o_ser(so1), .o_ser_valid(sv[1]), .o_par(pa1),
    .o_par_valid(pv[1]), .o_busy(bz[1])
  );

  shiftreg_univ #(.WIDTH(16), .LANES(4)) u_w16l4 (
    .clk(clk), .rst(rst), .i_load_valid(lv[2]), .o_load_ready(lr[2]),
    .i_load_data(ld[2][15:0]), .i_dir(dr[2]), .i_rot(rt[2]), .i_ser_en(en[2]),
    .i_ser(si[2][3:0]), .o_ser(so2), .o_ser_valid(sv[2]), .o_par(pa2),
    .o_par_valid(pv[2]), .o_busy(bz[2])
  );

  function automatic int wid(input int id);
    return (id == 2) ? 16 : 8;
  endfunction

  function automatic int lan(input int id);
    return (id == 0) ? 1 : ((id == 1) ? 2 : 4);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Loads one word and walks it to DONE; returns in the DONE cycle so a caller may chain a load.
  // Lane group k of fpat is the fill presented on beat k. mode: 0 en held, 1 toggle, 2 random.
  task automatic run_word(input int id, input logic [63:0] word, input logic dir,
                          input logic rot, input logic [63:0] fpat, input int mode,
                          input logic hold_next, input logic [63:0] next_word);
    int          w, l, n, k, cyc;
    logic [63:0] m, wm, fin, exp_o, fk;
    logic        e;
    w    = wid(id);
    l    = lan(id);
    n    = w / l;
    m    = (64'd1 << l) - 64'd1;
    wm   = (64'd1 << w) - 64'd1;
    word = word & wm;
    fin  = '0;
    for (int j = 0; j < n; j++) begin
      fk = (fpat >> (j * l)) & m;
      // Left: first fill ends up in the top slice; right: in the bottom slice.
      fin = fin | (dir ? (fk << (j * l)) : (fk << (w - (j + 1) * l)));
    end
    if (rot) fin = word;

    tests_run++;
    if (lr[id] !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_ready_before_load id%0d: got %b want 1", id, lr[id]);
    end
    lv[id] = 1'b1;
    ld[id] = word;
    dr[id] = dir;
    rt[id] = rot;
    en[id] = 1'($urandom % 2);
    si[id] = {$urandom, $urandom};
    step();
    cyc    = 1;
    k      = 0;
    lv[id] = hold_next;
    ld[id] = hold_next ? next_word : {$urandom, $urandom};

    while (k < n && cyc < 200) begin
      exp_o  = dir ? ((word >> (k * l)) & m) : ((word >> (w - (k + 1) * l)) & m);
      dr[id] = 1'($urandom % 2);
      rt[id] = 1'($urandom % 2);
      tests_run++;
      if (sv[id] !== 1'b1 || bz[id] !== 1'b1 || lr[id] !== 1'b0 || pv[id] !== 1'b0) begin
        tests_failed++;
        $display("FAIL shift_flags id%0d cyc%0d: got sv%b bz%b lr%b pv%b want sv1 bz1 lr0 pv0",
                 id, cyc, sv[id], bz[id], lr[id], pv[id]);
      end
      tests_run++;
      if (so[id] !== exp_o) begin
        tests_failed++;
        $display("FAIL o_ser id%0d beat%0d cyc%0d: got %h want %h", id, k, cyc, so[id], exp_o);
      end
      case (mode)
        0:       e = 1'b1;
        1:       e = (cyc % 2) == 1;
        default: e = ($urandom % 4) != 0;
      endcase
      en[id] = e;
      si[id] = e && !rot ? ((fpat >> (k * l)) & m) : {$urandom, $urandom};
      if (e) k++;
      step();
      cyc++;
    end
    en[id] = 1'b0;

    tests_run++;
    if (k < n) begin
      tests_failed++;
      $display("FAIL beat_budget id%0d: got %0d beats want %0d", id, k, n);
    end
    tests_run++;
    if (pv[id] !== 1'b1 || sv[id] !== 1'b0 || lr[id] !== 1'b1 || bz[id] !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_flags id%0d cyc%0d: got pv%b sv%b lr%b bz%b want pv1 sv0 lr1 bz1",
               id, cyc, pv[id], sv[id], lr[id], bz[id]);
    end
    tests_run++;
    if (pa[id] !== fin) begin
      tests_failed++;
      $display("FAIL o_par id%0d: got %h want %h", id, pa[id], fin);
    end
    if (mode == 0) begin
      tests_run++;
      if (cyc != n + 1) begin
        tests_failed++;
        $display("FAIL latency_held id%0d: got %0d want %0d", id, cyc, n + 1);
      end
    end else if (mode == 1) begin
      tests_run++;
      if (cyc != 2 * n) begin
        tests_failed++;
        $display("FAIL latency_toggle id%0d: got %0d want %0d", id, cyc, 2 * n);
      end
    end
  endtask

  task automatic idle_check(input int id);
    lv[id] = 1'b0;
    step();
    tests_run++;
    if (pv[id] !== 1'b0 || bz[id] !== 1'b0 || lr[id] !== 1'b1 || sv[id] !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_flags id%0d: got pv%b bz%b lr%b sv%b want pv0 bz0 lr1 sv0",
               id, pv[id], bz[id], lr[id], sv[id]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lv[i] = 1'b1;
      ld[i] = 64'hFFFF;
    end
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (lr[i] !== 1'b1 || bz[i] !== 1'b0 || sv[i] !== 1'b0 || pv[i] !== 1'b0 ||
          so[i] !== 64'd0 || pa[i] !== 64'd0) begin
        tests_failed++;
        $display("FAIL reset_state id%0d: got lr%b bz%b sv%b pv%b so%h par%h want 1 0 0 0 0 0",
                 i, lr[i], bz[i], sv[i], pv[i], so[i], pa[i]);
      end
      lv[i] = 1'b0;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_vectors();
    run_word(0, 64'hA5, 1'b0, 1'b0, 64'h00, 0, 1'b0, 64'd0);
    idle_check(0);
    run_word(1, 64'h81, 1'b1, 1'b1, 64'h00, 0, 1'b0, 64'd0);
    idle_check(1);
    // Fills 1,1,0,0,1,0,1,0 (beat 0 in bit 0).
    run_word(0, 64'h5A, 1'b0, 1'b0, 64'h53, 0, 1'b0, 64'd0);
    idle_check(0);
    run_word(2, 64'h1234, 1'b0, 1'b0, 64'hFFFF, 0, 1'b0, 64'd0);
    idle_check(2);
  endtask

  task automatic test_toggle_en();
    run_word(0, 64'h5A, 1'b0, 1'b0, 64'h53, 1, 1'b0, 64'd0);
    idle_check(0);
    run_word(2, 64'hBEEF, 1'b1, 1'b0, 64'h9C3A, 1, 1'b0, 64'd0);
    idle_check(2);
  endtask

  task automatic test_back_to_back();
    run_word(0, 64'hA5, 1'b0, 1'b0, 64'h6D, 0, 1'b1, 64'h3C);
    run_word(0, 64'h3C, 1'b1, 1'b0, 64'hB1, 0, 1'b0, 64'd0);
    idle_check(0);
  endtask

  task automatic test_rst_mid();
    lv[0] = 1'b1;
    ld[0] = 64'hA5;
    dr[0] = 1'b0;
    rt[0] = 1'b0;
    en[0] = 1'b1;
    si[0] = 64'd1;
    step();
    lv[0] = 1'b0;
    repeat (3) step();
    tests_run++;
    if (bz[0] !== 1'b1 || sv[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_rst_busy: got bz%b sv%b want bz1 sv1", bz[0], sv[0]);
    end
    rst   = 1'b1;
    lv[0] = 1'b1;
    ld[0] = 64'hFF;
    step();
    tests_run++;
    if (bz[0] !== 1'b0 || pv[0] !== 1'b0 || sv[0] !== 1'b0 || lr[0] !== 1'b1 ||
        pa[0] !== 64'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_state: got bz%b pv%b sv%b lr%b par%h want 0 0 0 1 00",
               bz[0], pv[0], sv[0], lr[0], pa[0]);
    end
    rst   = 1'b0;
    lv[0] = 1'b0;
    en[0] = 1'b0;
    idle_check(0);
    run_word(0, 64'hC3, 1'b1, 1'b0, 64'h2E, 0, 1'b0, 64'd0);
    idle_check(0);
  endtask

  task automatic test_random();
    int          id;
    logic [63:0] word;
    logic [63:0] nxt;
    logic        chain;
    chain = 1'b0;
    id    = 0;
    word  = '0;
    for (int it = 0; it < 60; it++) begin
      if (!chain) begin
        id   = int'($urandom % 3);
        word = {$urandom, $urandom};
      end
      nxt   = {$urandom, $urandom} & ((64'd1 << wid(id)) - 64'd1);
      chain = ($urandom % 3) == 0;
      run_word(id, word, 1'($urandom % 2), 1'($urandom % 2), {$urandom, $urandom},
               int'($urandom % 3), chain, nxt);
      if (chain) begin
        word = nxt;
      end else begin
        idle_check(id);
      end
    end
    if (chain) begin
      run_word(id, word, 1'b0, 1'b0, 64'd0, 0, 1'b0, 64'd0);
      idle_check(id);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lv[i] = 1'b0;
      ld[i] = '0;
      dr[i] = 1'b0;
      rt[i] = 1'b0;
      en[i] = 1'b0;
      si[i] = '0;
    end
    test_reset();
    test_vectors();
    test_toggle_en();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
